// File: rtl/ep6_packet_encoder.sv
// ep6_packet_encoder: round-robin scanner that packs EP6 read-port FIFO bytes into framed packets.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   fifo_in_addrs           : per-port FIFO write pointers, ADDR_W bits each
//   fifo_out_addrs          : per-port FIFO read pointers, same packing
//   fifo_read_datas         : per-port FIFO read data, valid one cycle after fifo_read
//   fifo_read               : one-hot read strobe, one byte per asserted cycle
//   ep6_data/valid/ready/last : outgoing byte stream {port, len_hi, len_lo, data..., [checksum]}
//   sent_byte_counts        : per-port 32-bit count of data bytes transferred
// Define EP6_PACKET_CHECKSUM_EN to append an XOR checksum byte after the data.
module ep6_packet_encoder #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 11,
    parameter int MAX_BURST = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] fifo_in_addrs,
    input  logic [NUM_PORTS*ADDR_W-1:0] fifo_out_addrs,
    input  logic [NUM_PORTS*8-1:0]    fifo_read_datas,
    output logic [NUM_PORTS-1:0]      fifo_read,
    output logic [7:0]                ep6_data,
    output logic                      ep6_valid,
    input  logic                      ep6_ready,
    output logic                      ep6_last,
    output logic [NUM_PORTS*32-1:0]   sent_byte_counts
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(MAX_BURST);

    typedef enum logic [2:0] {
        SCAN, HDR_PORT, HDR_LEN_HI, HDR_LEN_LO, DATA
`ifdef EP6_PACKET_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t state, state_next;
    logic [PW-1:0] scan_port, port;
    logic [ADDR_W-1:0] delta;
    logic [15:0] scan_len, len, rd_num, tx_num;
    logic [7:0] din, buf0, buf1;
    logic [1:0] occ;
    logic pend, rd_en, latch, last_data, data_xfer, push, pop;
`ifdef EP6_PACKET_CHECKSUM_EN
    logic [7:0] chk;
`endif

    assign delta    = fifo_in_addrs[scan_port*ADDR_W +: ADDR_W] - fifo_out_addrs[scan_port*ADDR_W +: ADDR_W];
    assign scan_len = (delta > MAX_LEN) ? 16'(MAX_LEN) : 16'(delta);
    assign din      = fifo_read_datas[port*8 +: 8];
    assign data_xfer = ep6_valid && ep6_ready && (state == DATA);
    // A byte arriving while the skid buffer is empty and the sink takes it bypasses the buffer.
    assign pop      = data_xfer && (occ != 2'd0);
    assign push     = pend && !(data_xfer && (occ == 2'd0));

    always_ff @(posedge clk) begin
        if (reset) state <= SCAN;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        ep6_valid  = 1'b0;
        ep6_data   = 8'h00;
        ep6_last   = 1'b0;
        last_data  = (tx_num == len - 16'd1);
        rd_en      = (state == HDR_LEN_LO || state == DATA) && (rd_num < len) &&
                     (({1'b0, occ} + {2'b00, pend}) < 3'd2);
        case (state)
            SCAN: begin
                latch      = (delta != '0);
                state_next = latch ? HDR_PORT : SCAN;
            end
            HDR_PORT: begin
                ep6_valid  = 1'b1;
                ep6_data   = 8'(port);
                state_next = ep6_ready ? HDR_LEN_HI : HDR_PORT;
            end
            HDR_LEN_HI: begin
                ep6_valid  = 1'b1;
                ep6_data   = len[15:8];
                state_next = ep6_ready ? HDR_LEN_LO : HDR_LEN_HI;
            end
            HDR_LEN_LO: begin
                ep6_valid  = 1'b1;
                ep6_data   = len[7:0];
                state_next = ep6_ready ? DATA : HDR_LEN_LO;
            end
            DATA: begin
                ep6_valid = (occ != 2'd0) || pend;
                ep6_data  = (occ != 2'd0) ? buf0 : din;
`ifdef EP6_PACKET_CHECKSUM_EN
                if (ep6_valid && ep6_ready && last_data) state_next = CHK;
`else
                ep6_last  = last_data;
                if (ep6_valid && ep6_ready && last_data) state_next = SCAN;
`endif
            end
`ifdef EP6_PACKET_CHECKSUM_EN
            CHK: begin
                ep6_valid  = 1'b1;
                ep6_data   = chk;
                ep6_last   = 1'b1;
                state_next = ep6_ready ? SCAN : CHK;
            end
`endif
            default: state_next = SCAN;
        endcase
        if (reset) begin
            ep6_valid = 1'b0;
            ep6_data  = 8'h00;
            ep6_last  = 1'b0;
            rd_en     = 1'b0;
            latch     = 1'b0;
        end
        fifo_read = rd_en ? (NUM_PORTS'(1) << port) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_port        <= '0;
            port             <= '0;
            len              <= '0;
            rd_num           <= '0;
            tx_num           <= '0;
            occ              <= '0;
            pend             <= 1'b0;
            buf0             <= '0;
            buf1             <= '0;
            sent_byte_counts <= '0;
        end else begin
            pend <= rd_en;
            if (state == SCAN) scan_port <= (scan_port == PW'(NUM_PORTS - 1)) ? '0 : scan_port + 1'b1;
            if (latch) begin
                port   <= scan_port;
                len    <= scan_len;
                rd_num <= '0;
                tx_num <= '0;
            end
            if (rd_en) rd_num <= rd_num + 16'd1;
            if (data_xfer) begin
                tx_num <= tx_num + 16'd1;
                sent_byte_counts[port*32 +: 32] <= sent_byte_counts[port*32 +: 32] + 32'd1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                buf0 <= occ[1] ? buf1 : din;
                if (push) buf1 <= din;
            end else if (push) begin
                if (occ == 2'd0) buf0 <= din;
                else buf1 <= din;
            end
        end
    end

`ifdef EP6_PACKET_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || latch) chk <= '0;
        else if (data_xfer) chk <= chk ^ ep6_data;
    end
`endif
endmodule
